// File: rtl/score_bcd_conv_pkg.sv
// rtl/score_bcd_conv_pkg.sv - shared types and constants for the score BCD converter
package score_bcd_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STORE,
    ST_DONE
  } state_t;

  localparam int         N_OPERANDS = 7;
  localparam int         SHIFT_BITS = 10;
  localparam int         BCD_W      = 16;
  localparam logic [9:0] BET_MAX    = 10'd999;
  localparam logic [2:0] BET_IDX    = 3'd6;

  // Four BCD digits top out at 9999, but the LCD field for the bet is three digits wide
  function automatic logic [9:0] sat_bet(input logic [9:0] v);
    return (v > BET_MAX) ? BET_MAX : v;
  endfunction

endpackage

// File: rtl/score_bcd_conv_bcd_add3.sv
// rtl/score_bcd_conv_bcd_add3.sv - double-dabble add-3 correction over a packed BCD accumulator
module bcd_add3
  import score_bcd_conv_pkg::*;
(
  input  logic [BCD_W-1:0] acc_in,
  output logic [BCD_W-1:0] acc_out
);

  // Any digit >= 5 would overflow past 9 after the next left shift, so pre-add 3
  always_comb begin
    acc_out = acc_in;
    for (int d = 0; d < BCD_W / 4; d++) begin
      if (acc_in[4*d +: 4] >= 4'd5) begin
        acc_out[4*d +: 4] = acc_in[4*d +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/score_bcd_conv.sv
// rtl/score_bcd_conv.sv - sequential binary-to-BCD converter for the seven LCD game fields
module score_bcd_conv
  import score_bcd_conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       p_score,
  input  logic [7:0]       d_score,
  input  logic [7:0]       p_fh,
  input  logic [7:0]       p_sh,
  input  logic [7:0]       d_fh,
  input  logic [7:0]       d_sh,
  input  logic [9:0]       bet,
  output logic [BCD_W-1:0] p_score_bcd,
  output logic [BCD_W-1:0] d_score_bcd,
  output logic [BCD_W-1:0] p_fh_bcd,
  output logic [BCD_W-1:0] p_sh_bcd,
  output logic [BCD_W-1:0] d_fh_bcd,
  output logic [BCD_W-1:0] d_sh_bcd,
  output logic [BCD_W-1:0] bet_bcd,
  output logic             busy,
  output logic             trigger
);

  state_t           state, state_nxt;
  logic [2:0]       idx;
  logic [3:0]       bit_cnt;
  logic [9:0]       shreg;
  logic [9:0]       operand;
  logic [BCD_W-1:0] acc, acc_adj;
  logic [9:0]       snap  [N_OPERANDS];
  logic [BCD_W-1:0] stage [N_OPERANDS];
  logic [BCD_W-1:0] out_q [N_OPERANDS];

  bcd_add3 u_add3 (
    .acc_in  (acc),
    .acc_out (acc_adj)
  );

  // Pick the snapshot currently being converted; the bet is clamped for its display field
  always_comb begin
    operand = snap[idx];
    if (idx == BET_IDX) begin
      operand = sat_bet(snap[idx]);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state sequencing: per operand one LOAD, ten SHIFTs, one STORE; DONE after the last
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    trigger   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == 4'(SHIFT_BITS - 1)) state_nxt = ST_STORE;
      ST_STORE: state_nxt = (idx == 3'(N_OPERANDS - 1)) ? ST_DONE : ST_LOAD;
      ST_DONE: begin
        trigger   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: snapshot, double-dabble shifting, staging, and the all-at-once output update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      acc     <= '0;
      for (int i = 0; i < N_OPERANDS; i++) begin
        snap[i]  <= '0;
        stage[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            snap[0] <= {2'b00, p_score};
            snap[1] <= {2'b00, d_score};
            snap[2] <= {2'b00, p_fh};
            snap[3] <= {2'b00, p_sh};
            snap[4] <= {2'b00, d_fh};
            snap[5] <= {2'b00, d_sh};
            snap[6] <= bet;
            idx     <= '0;
          end
        end
        ST_LOAD: begin
          shreg   <= operand;
          acc     <= '0;
          bit_cnt <= '0;
        end
        ST_SHIFT: begin
          {acc, shreg} <= {acc_adj, shreg} << 1;
          bit_cnt      <= bit_cnt + 4'd1;
        end
        ST_STORE: begin
          stage[idx] <= acc;
          if (idx != 3'(N_OPERANDS - 1)) idx <= idx + 3'd1;
        end
        ST_DONE: begin
          for (int i = 0; i < N_OPERANDS; i++) out_q[i] <= stage[i];
        end
        default: ;
      endcase
    end
  end

  assign p_score_bcd = out_q[0];
  assign d_score_bcd = out_q[1];
  assign p_fh_bcd    = out_q[2];
  assign p_sh_bcd    = out_q[3];
  assign d_fh_bcd    = out_q[4];
  assign d_sh_bcd    = out_q[5];
  assign bet_bcd     = out_q[6];

endmodule

// File: tb/tb_score_bcd_conv.sv
// tb/tb_score_bcd_conv.sv - self-checking bench for score_bcd_conv
module tb_score_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  p_score, d_score, p_fh, p_sh, d_fh, d_sh;
  logic [9:0]  bet;
  logic [15:0] p_score_bcd, d_score_bcd, p_fh_bcd, p_sh_bcd, d_fh_bcd, d_sh_bcd, bet_bcd;
  logic        busy, trigger;

  logic [111:0] out_flat;
  logic [111:0] cur_exp;
  int in_v   [7];
  int snap_v [7];
  int errors = 0;
  int checks = 0;

  score_bcd_conv dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .p_score     (p_score),
    .d_score     (d_score),
    .p_fh        (p_fh),
    .p_sh        (p_sh),
    .d_fh        (d_fh),
    .d_sh        (d_sh),
    .bet         (bet),
    .p_score_bcd (p_score_bcd),
    .d_score_bcd (d_score_bcd),
    .p_fh_bcd    (p_fh_bcd),
    .p_sh_bcd    (p_sh_bcd),
    .d_fh_bcd    (d_fh_bcd),
    .d_sh_bcd    (d_sh_bcd),
    .bet_bcd     (bet_bcd),
    .busy        (busy),
    .trigger     (trigger)
  );

  always #10 clk = ~clk;

  assign out_flat = {bet_bcd, d_sh_bcd, d_fh_bcd, p_sh_bcd, p_fh_bcd, d_score_bcd, p_score_bcd};

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [111:0] model_flat();
    logic [111:0] f;
    int v;
    for (int i = 0; i < 7; i++) begin
      v = snap_v[i];
      if (i == 6 && v > 999) v = 999;
      f[16*i +: 16] = to_bcd(v);
    end
    return f;
  endfunction

  task automatic drive_inputs();
    p_score = 8'(in_v[0]);
    d_score = 8'(in_v[1]);
    p_fh    = 8'(in_v[2]);
    p_sh    = 8'(in_v[3]);
    d_fh    = 8'(in_v[4]);
    d_sh    = 8'(in_v[5]);
    bet     = 10'(in_v[6]);
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 6; i++) in_v[i] = $urandom_range(0, 255);
    in_v[6] = $urandom_range(0, 1023);
  endtask

  // One conversion; optional second start (mid_start), input change (change_at), reset (reset_at)
  task automatic run_conv(input string name, input int mid_start, input int change_at, input int reset_at);
    logic [111:0] new_exp;
    logic [111:0] e_out;
    logic         e_trig, e_busy;
    bit           aborted;
    int           trig_cnt;
    @(negedge clk);
    drive_inputs();
    start = 1'b1;
    for (int i = 0; i < 7; i++) snap_v[i] = in_v[i];
    new_exp  = model_flat();
    aborted  = 0;
    trig_cnt = 0;
    @(posedge clk);
    for (int c = 1; c <= 92; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (reset_at != 0 && c == reset_at + 1) aborted = 1;
      e_trig = !aborted && (c == 85);
      e_busy = !aborted && (c <= 85);
      e_out  = aborted ? '0 : ((c >= 86) ? new_exp : cur_exp);
      if (trigger) trig_cnt++;
      checks++;
      if (trigger !== e_trig) begin
        errors++;
        $display("FAIL %s trigger c=%0d got=%b want=%b", name, c, trigger, e_trig);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL %s busy c=%0d got=%b want=%b", name, c, busy, e_busy);
      end
      checks++;
      if (out_flat !== e_out) begin
        errors++;
        $display("FAIL %s outputs c=%0d got=%h want=%h", name, c, out_flat, e_out);
      end
      if (c == mid_start) start = 1'b1;
      if (mid_start != 0 && c == mid_start + 1) start = 1'b0;
      if (c == change_at) begin
        randomize_inputs();
        drive_inputs();
      end
      if (reset_at != 0 && c == reset_at) rst_n = 1'b0;
      if (reset_at != 0 && c == reset_at + 1) rst_n = 1'b1;
    end
    checks++;
    if (trig_cnt != (aborted ? 0 : 1)) begin
      errors++;
      $display("FAIL %s trigger_count got=%0d want=%0d", name, trig_cnt, aborted ? 0 : 1);
    end
    cur_exp = aborted ? '0 : new_exp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    randomize_inputs();
    drive_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || trigger !== 1'b0) begin
      errors++;
      $display("FAIL reset busy/trigger got=%b%b want=00", busy, trigger);
    end
    checks++;
    if (out_flat !== '0) begin
      errors++;
      $display("FAIL reset outputs got=%h want=0", out_flat);
    end
    start   = 1'b0;
    rst_n   = 1'b1;
    cur_exp = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset idle_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_example();
    in_v = '{21, 17, 10, 11, 7, 10, 150};
    run_conv("example", 0, 0, 0);
    checks++;
    if (out_flat !== {16'h0150, 16'h0010, 16'h0007, 16'h0011, 16'h0010, 16'h0017, 16'h0021}) begin
      errors++;
      $display("FAIL example literal got=%h", out_flat);
    end
  endtask

  task automatic test_boundaries();
    in_v = '{255, 0, 99, 100, 9, 200, 1000};
    run_conv("bet1000", 0, 0, 0);
    checks++;
    if (bet_bcd !== 16'h0999 || p_score_bcd !== 16'h0255) begin
      errors++;
      $display("FAIL bet1000 literal got bet=%h p=%h want 0999 0255", bet_bcd, p_score_bcd);
    end
    in_v = '{255, 255, 255, 255, 255, 255, 1023};
    run_conv("bet1023", 0, 0, 0);
    checks++;
    if (bet_bcd !== 16'h0999 || d_sh_bcd !== 16'h0255) begin
      errors++;
      $display("FAIL bet1023 literal got bet=%h dsh=%h want 0999 0255", bet_bcd, d_sh_bcd);
    end
    in_v = '{0, 0, 0, 0, 0, 0, 0};
    run_conv("zeros", 0, 0, 0);
    checks++;
    if (out_flat !== '0) begin
      errors++;
      $display("FAIL zeros literal got=%h want=0", out_flat);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) begin
      randomize_inputs();
      run_conv("random", 0, 0, 0);
    end
  endtask

  task automatic test_ignored_start();
    randomize_inputs();
    run_conv("mid_start", 40, 0, 0);
  endtask

  task automatic test_input_change();
    randomize_inputs();
    run_conv("input_change", 0, 10, 0);
  endtask

  task automatic test_mid_reset();
    randomize_inputs();
    run_conv("mid_reset", 0, 0, 50);
    randomize_inputs();
    run_conv("after_reset", 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [111:0] exp_a, exp_b, e_out;
    logic         e_trig, e_busy;
    randomize_inputs();
    @(negedge clk);
    drive_inputs();
    start = 1'b1;
    for (int i = 0; i < 7; i++) snap_v[i] = in_v[i];
    exp_a = model_flat();
    exp_b = '0;
    @(posedge clk);
    for (int c = 1; c <= 176; c++) begin
      @(negedge clk);
      if (c == 2) begin
        randomize_inputs();
        drive_inputs();
        for (int i = 0; i < 7; i++) snap_v[i] = in_v[i];
        exp_b = model_flat();
      end
      if (c == 87) start = 1'b0;
      e_trig = (c == 85) || (c == 171);
      e_busy = (c <= 85) || (c >= 87 && c <= 171);
      e_out  = (c >= 172) ? exp_b : ((c >= 86) ? exp_a : cur_exp);
      checks++;
      if (trigger !== e_trig) begin
        errors++;
        $display("FAIL back_to_back trigger c=%0d got=%b want=%b", c, trigger, e_trig);
      end
      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL back_to_back busy c=%0d got=%b want=%b", c, busy, e_busy);
      end
      checks++;
      if (out_flat !== e_out) begin
        errors++;
        $display("FAIL back_to_back outputs c=%0d got=%h want=%h", c, out_flat, e_out);
      end
    end
    cur_exp = exp_b;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cur_exp = '0;
    for (int i = 0; i < 7; i++) in_v[i] = 0;
    drive_inputs();
    test_reset();
    test_example();
    test_boundaries();
    test_random();
    test_ignored_start();
    test_input_change();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_bcd_conv.md
SCORE_BCD_CONV -- requirements
Module: score_bcd_conv

Interface
REQ-001 SHALL have clk, input, 1, board 50 MHz clock; sole clock, all logic on rising edge.
REQ-002 SHALL have rst_n, input, 1, reset; one clock, synchronous, active-low.
REQ-003 SHALL have start, input, 1, request to convert the current game values.
REQ-004 SHALL have p_score, d_score, p_fh, p_sh, d_fh, d_sh, inputs, 8 each, unsigned binary player/dealer totals and hand cards.
REQ-005 SHALL have bet, input, 10, unsigned binary bet.
REQ-006 SHALL have p_score_bcd, d_score_bcd, p_fh_bcd, p_sh_bcd, d_fh_bcd, d_sh_bcd, bet_bcd, outputs, 16 each; 4 packed BCD digits, [15:12] thousands down to [3:0] units; these feed the LCD writer.
REQ-007 SHALL have busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have trigger, output, 1, one-cycle pulse on completion; drives the LCD writer's refresh trigger.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, SHIFT, STORE, DONE.
REQ-010 In IDLE with start=1, SHALL snapshot all seven inputs into internal copies, set operand index to 0, go to LOAD; later input changes SHALL NOT affect this conversion.
REQ-011 LOAD (1 cycle): SHALL place operand[index], zero-extended to 10 bits, into the shift register and clear the 16-bit BCD accumulator.
REQ-012 Bet operand SHALL saturate to 999 when the snapshot exceeds 999.
REQ-013 SHIFT (exactly 10 cycles): each cycle SHALL add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by one bit.
REQ-014 STORE (1 cycle): SHALL write the accumulator into the staging register for index; if index=6 go to DONE, else increment index and go to LOAD.
REQ-015 Operand order SHALL be p_score, d_score, p_fh, p_sh, d_fh, d_sh, bet (index 0..6).
REQ-016 DONE (1 cycle): SHALL copy all seven staging registers to the outputs simultaneously, pulse trigger=1, return to IDLE.
REQ-017 Outputs SHALL change only in DONE; the LCD writer never sees a partial update.
REQ-018 Latency: trigger SHALL be high exactly 85 cycles after the edge that sampled start (7 x 12 cycles + DONE).
REQ-019 busy SHALL be 1 in LOAD, SHIFT, STORE, DONE; 0 in IDLE.
REQ-020 start while busy=1 SHALL be ignored, not queued.
REQ-021 start held high continuously SHALL start a new conversion on the cycle after DONE.
REQ-022 8-bit operands SHALL produce thousands digit 0; maximum 255 gives 16'h0255.
REQ-023 trigger SHALL be 0 in every state except DONE.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force IDLE, busy=0, trigger=0, index=0, all seven outputs and staging registers to 16'h0000.
REQ-025 Reset mid-conversion SHALL abandon it without a trigger pulse; outputs read 16'h0000 on the following cycle.
REQ-026 First start after rst_n returns high SHALL behave as REQ-010.

Structure
REQ-027 Shared package SHALL hold: state encoding, N_OPERANDS=7, SHIFT_BITS=10, BET_MAX=999, BCD_W=16.
REQ-028 One combinational sub-module bcd_add3 (16-bit accumulator in, add-3-corrected accumulator out) SHALL be instantiated in the SHIFT datapath.
REQ-029 Implementation SHALL be synthesizable for the Spartan-3E target and require no memories.

Verification
REQ-030 Reset, then p_score=21, d_score=17, p_fh=10, p_sh=11, d_fh=7, d_sh=10, bet=150, start pulse -> trigger high at cycle 85; outputs 16'h0021, 16'h0017, 16'h0010, 16'h0011, 16'h0007, 16'h0010, 16'h0150.
REQ-031 bet=1000 and bet=1023 -> bet_bcd=16'h0999; p_score=255 -> 16'h0255; all operands 0 -> all outputs 16'h0000.
REQ-032 Second start pulse at cycle 40 of a conversion -> ignored; exactly one trigger pulse at cycle 85.
REQ-033 Inputs changed at cycle 10 after start -> outputs reflect the values sampled at start.
REQ-034 rst_n low at cycle 50 of a conversion -> no trigger, busy=0, all outputs 16'h0000 next cycle.
REQ-035 Outputs checked every cycle -> constant except at the DONE edge; trigger width exactly 1 cycle.
